// File: rtl/rdm_harq_combiner_pkg.sv
// Shared constants for the RDM-to-HARQ soft combiner: FSM encodings and
// LLR lane packing.
package rdm_harq_combiner_pkg;

    localparam int LLR_W  = 6;
    localparam int LANES  = 16;
    localparam int WORD_W = LANES * LLR_W;

    // IDLE is all-zero, every active state owns one bit
    localparam logic [4:0] ST_IDLE  = 5'b00000;
    localparam logic [4:0] ST_REQ   = 5'b00001;
    localparam logic [4:0] ST_ARM   = 5'b00010;
    localparam logic [4:0] ST_RECV  = 5'b00100;
    localparam logic [4:0] ST_FLUSH = 5'b01000;
    localparam logic [4:0] ST_DONE  = 5'b10000;

    typedef logic [LANES-1:0] lane_mask_t;

    // Lanes below last_lanes are live in the tail word; 0 means a full word.
    function automatic lane_mask_t tail_mask(input logic [3:0] last_lanes);
        lane_mask_t m;
        for (int k = 0; k < LANES; k++)
            m[k] = (last_lanes == 4'd0) || (k < int'(last_lanes));
        return m;
    endfunction

endpackage

// File: rtl/rdm_harq_combiner_if.sv
// RDM data handshake between the RDM read FSM (master) and the combiner (slave).
interface rdm_harq_combiner_if;
    import rdm_harq_combiner_pkg::*;

    logic              o_Combine_process_request;
    logic [3:0]        o_Combine_user_index;
    logic              o_RDM_Data_Request;
    logic              i_RDM_Data_Valid;
    logic              i_RDM_Data_Comp;
    logic [WORD_W-1:0] i_RDM_Data_Content;

    modport master (
        input  o_Combine_process_request, o_Combine_user_index, o_RDM_Data_Request,
        output i_RDM_Data_Valid, i_RDM_Data_Comp, i_RDM_Data_Content
    );

    modport slave (
        output o_Combine_process_request, o_Combine_user_index, o_RDM_Data_Request,
        input  i_RDM_Data_Valid, i_RDM_Data_Comp, i_RDM_Data_Content
    );

endinterface

// File: rtl/rdm_harq_combiner_llr_sat_add16.sv
// 16-lane saturating LLR adder. Masked-off lanes pass the old value through.
module llr_sat_add16
    import rdm_harq_combiner_pkg::*;
#(
    parameter int LLR_WIDTH = LLR_W
) (
    input  logic [LANES*LLR_WIDTH-1:0] old_i,
    input  logic [LANES*LLR_WIDTH-1:0] new_i,
    input  logic [LANES-1:0]           mask_i,
    output logic [LANES*LLR_WIDTH-1:0] sum_o
);

    localparam logic [LLR_WIDTH-1:0] LLR_MAX = {1'b0, {(LLR_WIDTH-1){1'b1}}};
    localparam logic [LLR_WIDTH-1:0] LLR_MIN = {1'b1, {(LLR_WIDTH-1){1'b0}}};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LLR_WIDTH-1:0] a, b, r;
        logic [LLR_WIDTH:0]   s;

        assign a = old_i[k*LLR_WIDTH +: LLR_WIDTH];
        assign b = new_i[k*LLR_WIDTH +: LLR_WIDTH];
        assign s = {a[LLR_WIDTH-1], a} + {b[LLR_WIDTH-1], b};
        // Overflow when the extra sign bit disagrees; its value picks the rail
        assign r = (s[LLR_WIDTH] != s[LLR_WIDTH-1]) ? (s[LLR_WIDTH] ? LLR_MIN : LLR_MAX)
                                                    : s[LLR_WIDTH-1:0];
        assign sum_o[k*LLR_WIDTH +: LLR_WIDTH] = mask_i[k] ? r : a;
    end

endmodule

// File: rtl/rdm_harq_combiner.sv
// Pulls rate-dematched LLR words from the RDM FSM and soft-combines them into
// the circular Ncb-sized HARQ buffer through a 2-stage read-modify-write pipe.
module rdm_harq_combiner
    import rdm_harq_combiner_pkg::*;
#(
    parameter int CB_ADDR_WIDTH = 12,
    parameter int LLR_WIDTH     = LLR_W
) (
    input  logic                       i_core_clk,
    input  logic                       i_rx_rstn,
    input  logic                       i_rx_fsm_rstn,
    input  logic                       i_start,
    input  logic [3:0]                 i_user_index,
    input  logic [15:0]                i_ncb_size,
    input  logic                       i_first_tx,
    rdm_harq_combiner_if.slave         rdm,
    output logic                       o_cb_rd_en,
    output logic [CB_ADDR_WIDTH-1:0]   o_cb_rd_addr,
    input  logic [LANES*LLR_WIDTH-1:0] i_cb_rd_data,
    output logic                       o_cb_wr_en,
    output logic [CB_ADDR_WIDTH-1:0]   o_cb_wr_addr,
    output logic [LANES*LLR_WIDTH-1:0] o_cb_wr_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [15:0]                o_words_received
);

    localparam int WW = LANES * LLR_WIDTH;

    logic rst_n;
    assign rst_n = i_rx_rstn & i_rx_fsm_rstn;

    logic [4:0]  state_q, state_d;
    logic        flush_q, flush_d;
    logic [3:0]  user_q;
    logic        first_q;
    logic [15:0] ncb_last_q, ncb_last_w;
    logic [3:0]  last_lanes_q;

    logic [CB_ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic                     pass_q, pass_d;
    logic [15:0]              words_q, words_d;

    // [0] stage 1 holds a word, [1] stage 2 is writing, [2] previous write held for forwarding
    logic [2:0]               vld_pipe_q;
    logic [WW-1:0]            s1_word_q;
    logic [CB_ADDR_WIDTH-1:0] s1_addr_q;
    logic                     s1_pass_q, s1_last_q;
    logic [CB_ADDR_WIDTH-1:0] s2_addr_q, wb_addr_q;
    logic [WW-1:0]            s2_data_q, wb_data_q;

    logic          accept, is_last, overwrite, start_ok;
    logic [WW-1:0] fwd_old, old_eff, comb_word;
    lane_mask_t    lane_mask;

    assign start_ok   = (state_q == ST_IDLE) && i_start;
    assign accept     = rdm.i_RDM_Data_Valid && ((state_q == ST_ARM) || (state_q == ST_RECV));
    assign ncb_last_w = {4'd0, i_ncb_size[15:4]} - {15'd0, (i_ncb_size[3:0] == 4'd0)};
    assign is_last    = ({{(16-CB_ADDR_WIDTH){1'b0}}, wptr_q} == ncb_last_q);

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_REQ;
            ST_REQ:   state_d = ST_ARM;
            ST_ARM: begin
                if (rdm.i_RDM_Data_Comp) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b0;
                end else if (rdm.i_RDM_Data_Valid) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (rdm.i_RDM_Data_Comp) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (flush_q) state_d = ST_DONE;
                else         flush_d = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        pass_d  = pass_q;
        words_d = words_q;
        if (start_ok) begin
            wptr_d  = '0;
            pass_d  = 1'b0;
            words_d = '0;
        end else if (accept) begin
            wptr_d = is_last ? '0 : wptr_q + 1'b1;
            if (is_last) pass_d = 1'b1;
            if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
        end
    end

    // Forward from the write in flight, then from the one just committed, since a
    // read-first RAM returns stale data for a read issued alongside that write.
    always_comb begin
        fwd_old = i_cb_rd_data;
        if (vld_pipe_q[1] && (s2_addr_q == s1_addr_q))
            fwd_old = s2_data_q;
        else if (vld_pipe_q[2] && (wb_addr_q == s1_addr_q))
            fwd_old = wb_data_q;
    end

    // Overwrite is a combine onto zero; masked tail lanes then come out as zero too.
    assign overwrite = first_q && !s1_pass_q;
    assign old_eff   = overwrite ? '0 : fwd_old;
    assign lane_mask = s1_last_q ? tail_mask(last_lanes_q) : '1;

    llr_sat_add16 #(.LLR_WIDTH(LLR_WIDTH)) u_sat_add (
        .old_i  (old_eff),
        .new_i  (s1_word_q),
        .mask_i (lane_mask),
        .sum_o  (comb_word)
    );

    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            flush_q      <= 1'b0;
            user_q       <= '0;
            first_q      <= 1'b0;
            ncb_last_q   <= '0;
            last_lanes_q <= '0;
            wptr_q       <= '0;
            pass_q       <= 1'b0;
            words_q      <= '0;
            vld_pipe_q   <= '0;
            s1_word_q    <= '0;
            s1_addr_q    <= '0;
            s1_pass_q    <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_addr_q    <= '0;
            s2_data_q    <= '0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            wptr_q     <= wptr_d;
            pass_q     <= pass_d;
            words_q    <= words_d;
            vld_pipe_q <= {vld_pipe_q[1:0], accept};
            if (start_ok) begin
                user_q       <= i_user_index;
                first_q      <= i_first_tx;
                ncb_last_q   <= ncb_last_w;
                last_lanes_q <= i_ncb_size[3:0];
            end
            if (accept) begin
                s1_word_q <= rdm.i_RDM_Data_Content;
                s1_addr_q <= wptr_q;
                s1_pass_q <= pass_q;
                s1_last_q <= is_last;
            end
            if (vld_pipe_q[0]) begin
                s2_addr_q <= s1_addr_q;
                s2_data_q <= comb_word;
            end
            if (vld_pipe_q[1]) begin
                wb_addr_q <= s2_addr_q;
                wb_data_q <= s2_data_q;
            end
        end
    end

    assign rdm.o_Combine_process_request = (state_q == ST_REQ);
    assign rdm.o_Combine_user_index      = user_q;
    assign rdm.o_RDM_Data_Request        = (state_q == ST_ARM);

    assign o_cb_rd_en       = accept;
    assign o_cb_rd_addr     = wptr_q;
    assign o_cb_wr_en       = vld_pipe_q[1];
    assign o_cb_wr_addr     = s2_addr_q;
    assign o_cb_wr_data     = s2_data_q;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_done           = (state_q == ST_DONE);
    assign o_words_received = words_q;

endmodule

// File: tb/tb_rdm_harq_combiner.sv
// Directed bench for rdm_harq_combiner with a read-first 1-cycle buffer RAM model.
module tb_rdm_harq_combiner;
    import rdm_harq_combiner_pkg::*;

    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, fsm_rstn, start, first_tx;
    logic [3:0]  user;
    logic [15:0] ncb;
    logic        rd_en, wr_en, busy, done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [95:0] rd_data = '0;
    logic [95:0] wr_data;
    logic [15:0] words;

    rdm_harq_combiner_if rif();

    rdm_harq_combiner #(.CB_ADDR_WIDTH(AW), .LLR_WIDTH(6)) dut (
        .i_core_clk       (clk),
        .i_rx_rstn        (rstn),
        .i_rx_fsm_rstn    (fsm_rstn),
        .i_start          (start),
        .i_user_index     (user),
        .i_ncb_size       (ncb),
        .i_first_tx       (first_tx),
        .rdm              (rif),
        .o_cb_rd_en       (rd_en),
        .o_cb_rd_addr     (rd_addr),
        .i_cb_rd_data     (rd_data),
        .o_cb_wr_en       (wr_en),
        .o_cb_wr_addr     (wr_addr),
        .o_cb_wr_data     (wr_data),
        .o_busy           (busy),
        .o_done           (done),
        .o_words_received (words)
    );

    logic [95:0] mem [0:15];
    logic [95:0] wlog [0:63];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_addr = '0;
    logic [95:0] pl_data = '0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (wr_en) begin
            mem[wr_addr[3:0]]  <= wr_data;
            wlog[wr_cnt[5:0]]  <= wr_data;
            wr_cnt             <= wr_cnt + 1;
        end
        if (rd_en) rd_data <= mem[rd_addr[3:0]];
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] fill(input int v);
        logic [95:0] r;
        for (int k = 0; k < 16; k++) r[k*6 +: 6] = v[5:0];
        return r;
    endfunction

    function automatic logic [95:0] ramp(input int b);
        logic [95:0] r;
        int v;
        for (int k = 0; k < 16; k++) begin
            v = b + k;
            r[k*6 +: 6] = v[5:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [95:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic start_pass(input logic [3:0] u, input logic [15:0] n, input logic f);
        int t;
        start = 1'b1; user = u; ncb = n; first_tx = f;
        tick();
        start = 1'b0;
        t = 0;
        while (!rif.o_RDM_Data_Request && t < 20) begin
            tick();
            t++;
        end
        chk("arm_reached", 96'(rif.o_RDM_Data_Request), 96'd1);
    endtask

    task automatic send(input logic [95:0] w, input logic comp);
        rif.i_RDM_Data_Valid = 1'b1; rif.i_RDM_Data_Content = w; rif.i_RDM_Data_Comp = comp;
        tick();
        rif.i_RDM_Data_Valid = 1'b0; rif.i_RDM_Data_Comp = 1'b0;
    endtask

    task automatic send_comp();
        rif.i_RDM_Data_Comp = 1'b1;
        tick();
        rif.i_RDM_Data_Comp = 1'b0;
    endtask

    // Cycle index of o_done counting the comp cycle as 0; returns to IDLE after.
    task automatic finish_pass(output int lat);
        lat = 1;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [95:0] w [0:3];
    logic [95:0] e;
    int lat, base, v;

    initial begin
        rstn = 1'b0; fsm_rstn = 1'b1; start = 1'b0; first_tx = 1'b0; user = '0; ncb = '0;
        rif.i_RDM_Data_Valid = 1'b0; rif.i_RDM_Data_Comp = 1'b0; rif.i_RDM_Data_Content = '0;
        repeat (3) tick();
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_strobes", 96'({rd_en, wr_en, done, rif.o_Combine_process_request, rif.o_RDM_Data_Request}), 96'd0);
        chk("rst_words", 96'(words), 96'd0);
        rstn = 1'b1;
        tick();

        // Single first-tx pass over 4 words
        base = wr_cnt;
        start = 1'b1; user = 4'd5; ncb = 16'd64; first_tx = 1'b1;
        tick();
        start = 1'b0;
        chk("req_pulse", 96'(rif.o_Combine_process_request), 96'd1);
        chk("busy_req", 96'(busy), 96'd1);
        chk("user_idx", 96'(rif.o_Combine_user_index), 96'd5);
        tick();
        chk("arm_req", 96'(rif.o_RDM_Data_Request), 96'd1);
        for (int i = 0; i < 4; i++) w[i] = ramp(i*3 - 10);
        for (int i = 0; i < 4; i++) send(w[i], 1'b0);
        send_comp();
        finish_pass(lat);
        chk("t1_done_lat", 96'(lat), 96'd3);
        chk("t1_wr_count", 96'(wr_cnt - base), 96'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_mem%0d", i), mem[i], w[i]);
        chk("t1_words", 96'(words), 96'd4);
        chk("t1_idle", 96'(busy), 96'd0);

        // Repetition wrap: Ncb=32, five words of +20
        base = wr_cnt;
        start_pass(4'd0, 16'd32, 1'b1);
        for (int i = 0; i < 5; i++) send(fill(20), i == 4);
        finish_pass(lat);
        chk("t2_wr0", wlog[base], fill(20));
        chk("t2_wr1", wlog[base+1], fill(20));
        chk("t2_wr2_sat", wlog[base+2], fill(31));
        chk("t2_mem0", mem[0], fill(31));
        chk("t2_mem1", mem[1], fill(31));
        chk("t2_words", 96'(words), 96'd5);

        // Retransmission onto -20
        preload(4'd0, fill(-20));
        preload(4'd1, fill(-20));
        start_pass(4'd1, 16'd32, 1'b0);
        send(fill(-20), 1'b0);
        send(fill(5), 1'b1);
        finish_pass(lat);
        chk("t3_neg_sat", mem[0], fill(-32));
        chk("t3_mixed", mem[1], fill(-15));

        // Partial tail word: Ncb=20, last_lanes=4
        preload(4'd1, fill(7));
        start_pass(4'd2, 16'd20, 1'b1);
        send(ramp(-5), 1'b0);
        send(ramp(1), 1'b1);
        finish_pass(lat);
        e = '0;
        for (int k = 0; k < 4; k++) begin
            v = k + 1;
            e[k*6 +: 6] = v[5:0];
        end
        chk("t4_mem0", mem[0], ramp(-5));
        chk("t4_tail_zero", mem[1], e);
        start_pass(4'd3, 16'd20, 1'b0);
        send(fill(1), 1'b0);
        send(fill(1), 1'b1);
        finish_pass(lat);
        e = '0;
        for (int k = 0; k < 4; k++) begin
            v = k + 2;
            e[k*6 +: 6] = v[5:0];
        end
        chk("t4_retx_mem0", mem[0], ramp(-4));
        chk("t4_tail_keep", mem[1], e);

        // Single-word buffer, back-to-back: forwarding path
        preload(4'd0, '0);
        base = wr_cnt;
        start_pass(4'd4, 16'd16, 1'b0);
        send(fill(1), 1'b0);
        send(fill(1), 1'b0);
        send(fill(1), 1'b1);
        finish_pass(lat);
        chk("t5_wr1", wlog[base+1], fill(2));
        chk("t5_mem0", mem[0], fill(3));

        // Valid while IDLE is ignored
        base = wr_cnt;
        rif.i_RDM_Data_Valid = 1'b1; rif.i_RDM_Data_Content = fill(9);
        #1;
        chk("idle_rd_en", 96'(rd_en), 96'd0);
        tick(); tick();
        rif.i_RDM_Data_Valid = 1'b0;
        tick(); tick();
        chk("idle_no_wr", 96'(wr_cnt - base), 96'd0);

        // Comp with no data
        start_pass(4'd5, 16'd64, 1'b1);
        send_comp();
        finish_pass(lat);
        chk("empty_lat", 96'(lat), 96'd3);
        chk("empty_no_wr", 96'(wr_cnt - base), 96'd0);
        chk("empty_words", 96'(words), 96'd0);

        // FSM reset mid-RECV with a write in flight
        start_pass(4'd6, 16'd64, 1'b1);
        send(fill(2), 1'b0);
        send(fill(3), 1'b0);
        rif.i_RDM_Data_Valid = 1'b1; rif.i_RDM_Data_Content = fill(4);
        fsm_rstn = 1'b0;
        #1;
        chk("frst_wr_en", 96'(wr_en), 96'd0);
        chk("frst_rd_en", 96'(rd_en), 96'd0);
        chk("frst_ctl", 96'({busy, done, rif.o_Combine_process_request, rif.o_RDM_Data_Request}), 96'd0);
        chk("frst_words", 96'(words), 96'd0);
        tick();
        rif.i_RDM_Data_Valid = 1'b0;
        fsm_rstn = 1'b1;
        tick();
        base = wr_cnt;
        start_pass(4'd7, 16'd16, 1'b1);
        send(fill(9), 1'b1);
        finish_pass(lat);
        chk("post_rst_lat", 96'(lat), 96'd3);
        chk("post_rst_mem0", mem[0], fill(9));
        chk("post_rst_wr_count", 96'(wr_cnt - base), 96'd1);
        chk("post_rst_words", 96'(words), 96'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
